// File: rtl/as_dmem_back.sv
// as_dmem_back: load-side back end of the data memory path.
// Tracks each load through the RAM read latency, then extracts and extends
// the addressed byte/half/word/double into a registered writeback result.

package as_pack;
  localparam int reg_width       = 64;
  localparam int dmem_addr_width = 16;
endpackage

module as_dmem_back
  import as_pack::*;
#(
  parameter int unsigned RD_LAT = 1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       req_valid_i,
  input  logic [dmem_addr_width-1:0] addr_i,
  input  logic [2:0]                 func3_i,
  input  logic [4:0]                 rd_addr_i,
  input  logic                       flush_i,
  input  logic [reg_width-1:0]       dataFromMem_i,
  output logic                       rsp_valid_o,
  output logic [reg_width-1:0]       dataToRegFile_o,
  output logic [4:0]                 rd_addr_o,
  output logic                       misalign_o,
  output logic                       busy_o
);

  typedef struct packed {
    logic       valid;
    logic [2:0] off;
    logic [2:0] func3;
    logic [4:0] rd;
    logic       mis;
  } meta_t;

  meta_t [RD_LAT-1:0] st;
  meta_t              cap;
  meta_t              last;
  logic [31:0]        lane;
  logic [reg_width-1:0] ext;
  logic               any_valid;

  // Only the byte offset within the 64-bit word matters here.
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr_i[dmem_addr_width-1:3];

  // Build the stage-0 entry, including the alignment check for the load size.
  always_comb begin
    cap       = '0;
    cap.valid = req_valid_i;
    cap.off   = addr_i[2:0];
    cap.func3 = func3_i;
    cap.rd    = rd_addr_i;
    case (func3_i[1:0])
      2'b00:   cap.mis = 1'b0;
      2'b01:   cap.mis = addr_i[0];
      2'b10:   cap.mis = |addr_i[1:0];
      default: cap.mis = |addr_i[2:0];
    endcase
  end

  // Metadata pipeline aligned with the RAM read latency; flush kills valids only.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      st <= '0;
    end else if (flush_i) begin
      for (int unsigned i = 0; i < RD_LAT; i++) begin
        st[i].valid <= 1'b0;
      end
    end else begin
      st[0] <= cap;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        st[i] <= st[i-1];
      end
    end
  end

  assign last = st[RD_LAT-1];

  // Shifting by the byte offset serves every aligned size; misaligned
  // loads are forced to zero anyway, so no per-size lane mux is needed.
  assign lane = 32'(dataFromMem_i >> {last.off, 3'b000});

  // Select the field for the load size and sign- or zero-extend it.
  always_comb begin
    ext = '0;
    case (last.func3[1:0])
      2'b00:   ext = {{56{~last.func3[2] & lane[7]}},  lane[7:0]};
      2'b01:   ext = {{48{~last.func3[2] & lane[15]}}, lane[15:0]};
      2'b10:   ext = {{32{~last.func3[2] & lane[31]}}, lane[31:0]};
      default: ext = dataFromMem_i;
    endcase
    if (last.mis) begin
      ext = '0;
    end
  end

  // Output register: result fields update only when a load returns.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rsp_valid_o     <= 1'b0;
      dataToRegFile_o <= '0;
      rd_addr_o       <= '0;
      misalign_o      <= 1'b0;
    end else if (flush_i) begin
      rsp_valid_o <= 1'b0;
    end else begin
      rsp_valid_o <= last.valid;
      if (last.valid) begin
        dataToRegFile_o <= ext;
        rd_addr_o       <= last.rd;
        misalign_o      <= last.mis;
      end
    end
  end

  // Busy while any stage or the output holds a live load.
  always_comb begin
    any_valid = 1'b0;
    for (int unsigned i = 0; i < RD_LAT; i++) begin
      any_valid = any_valid | st[i].valid;
    end
  end

  assign busy_o = any_valid | rsp_valid_o;

endmodule

// File: doc/as_dmem_back.md
# as_dmem_back

Load-side back end of the data memory path, the read-direction counterpart of the store formatter (as_dmem_front). It tracks each load issued to the synchronous data RAM and carries its offset, width and destination tag through the RAM read latency. When the 64-bit RAM word returns, the block extracts the addressed byte, half, word or double, sign- or zero-extends it, and delivers a registered result toward register-file writeback. It sits between the data RAM read port and the writeback stage.

## Interface
- RD_LAT, 1: RAM read latency in cycles, from address presented to dataFromMem_i valid; legal range 1..4.
- reg_width and dmem_addr_width come from as_pack (reg_width = 64).

Ports:
- clk_i  in  1  single clock; all state updates on rising edge.
- rst_i  in  1  reset, asynchronous and active-high.
- req_valid_i  in  1  a load address is presented to the RAM this cycle.
- addr_i  in  dmem_addr_width  byte address of the load; only bits [2:0] are retained.
- func3_i  in  3  load type: 000 lb, 001 lh, 010 lw, 011 ld, 100 lbu, 101 lhu, 110 lwu, 111 treated as ld.
- rd_addr_i  in  5  destination register tag, returned unchanged.
- flush_i  in  1  pipeline kill; drops all in-flight and same-cycle requests.
- dataFromMem_i  in  reg_width  RAM read data, valid RD_LAT cycles after its request.
- rsp_valid_o  out  1  result valid (one-cycle pulse per load).
- dataToRegFile_o  out  reg_width  extended load result.
- rd_addr_o  out  5  tag of the load being returned.
- misalign_o  out  1  the returning load was misaligned; qualified by rsp_valid_o.
- busy_o  out  1  at least one load is in flight or on the output.

## Operation
- Metadata pipeline has RD_LAT stages. Each stage holds {valid, off[2:0], func3, rd, misalign}. Stage 0 captures the request; stage RD_LAT-1 lines up with dataFromMem_i.
- Misalignment is computed at capture:
  - lh/lhu: off[0] != 0
  - lw/lwu: off[1:0] != 0
  - ld/111: off[2:0] != 0
  - lb/lbu: never misaligned
- Extraction is combinational from the last stage plus dataFromMem_i, using lane = off:
  - byte: dataFromMem_i[8*off +: 8]
  - half: [16*off[2:1] +: 16]
  - word: [32*off[2] +: 32]
  - double: the full word
- Extension: lb/lh/lw sign-extend from the top bit of the extracted field. lbu/lhu/lwu zero-extend.
- A misaligned load produces dataToRegFile_o = 0 and misalign_o = 1. No extraction is attempted.
- The output register captures the extracted result, rd and misalign when the last stage is valid. rsp_valid_o follows the last-stage valid.
- When no response is valid, dataToRegFile_o, rd_addr_o and misalign_o hold their last values. misalign_o is meaningful only while rsp_valid_o = 1.
- flush_i, sampled at the clock edge:
  - clears every stage valid and rsp_valid_o;
  - drops a request presented in the same cycle;
  - leaves data/tag registers unchanged.
- busy_o = OR of all stage valids and rsp_valid_o.

## Timing
- Request at edge t gives rsp_valid_o high during cycle t+RD_LAT+1, i.e. total latency RD_LAT+1.
- Fully pipelined: one request per cycle, no stalls, no backpressure. Responses return in issue order.
- Consecutive requests produce consecutive rsp_valid_o pulses with no bubbles.
- Reset (asynchronous, at any time including mid-load) forces:
  - all stage valids = 0, rsp_valid_o = 0, misalign_o = 0, busy_o = 0;
  - dataToRegFile_o = 0, rd_addr_o = 0.
  - In-flight loads are lost.
- First request is accepted on the first rising edge after rst_i deasserts.
- Flush and request in the same cycle: the flush wins and the request is lost.
- A request on the cycle after a flush is accepted normally.

## Test plan
- RAM word 0xF1E2D3C4B5A69788, RD_LAT=1: lb off 0 -> 0xFFFFFFFFFFFFFF88; lbu off 7 -> 0x00000000000000F1; each with rsp_valid_o 2 cycles after the request.
- Same word: lh off 2 -> 0xFFFFFFFFFFFFB5A6; lhu off 6 -> 0x000000000000F1E2; lw off 0 -> 0xFFFFFFFFB5A69788; lwu off 4 -> 0x00000000F1E2D3C4; ld off 0 -> 0xF1E2D3C4B5A69788.
- Misaligned cases: lw off 2, lh off 3 and ld off 4 -> each gives rsp_valid_o=1, misalign_o=1, data 0. lb off 5 gives misalign_o=0.
- Back-to-back stream of 8 loads with rd 1..8 at RD_LAT=3 -> 8 consecutive pulses starting 4 cycles after the first request, rd_addr_o = 1..8 in order, busy_o high throughout.
- Flush with 3 loads in flight plus a same-cycle request -> no rsp_valid_o for any of the 4. busy_o=0 on the next cycle. A load issued the following cycle returns normally.
- rst_i asserted asynchronously mid-stream, between edges -> outputs zero immediately and no pulses follow. After release, lbu off 1 of 0x0000000000001200 -> 0x12.
